// File: rtl/fwd_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : fwd_clk_gen
// Description : Forwarded-clock generator. It produces a programmable-period
//               square wave with glitch-free start and stop, and it takes the
//               divider value through a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_clk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_fpga_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_vld,
    output logic             o_div_ack,
    output logic             o_fwd_clk,
    output logic             o_running,
    output logic             o_edge_rise,
    output logic [CNT_W-1:0] o_cyc_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_act_q, div_act_d;
    logic [DIV_W-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               ack_q, ack_d;
    logic               fwd_q, fwd_d;
    logic               rise_q, rise_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;

    logic               w_phase_end;
    logic               w_rise_gen;
    logic               w_xfer;
    logic               w_capture;

    assign w_phase_end = (cnt_q == (div_act_q - DIV_W'(1)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fwd_d       = fwd_q;
        w_rise_gen  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                fwd_d = 1'b0;
                if (i_en) begin
                    state_d    = S_RUN;
                    fwd_d      = 1'b1;
                    w_rise_gen = 1'b1;
                end
            end
            S_RUN: begin
                if (!i_en) state_d = S_STOP;
                if (w_phase_end) begin
                    cnt_d      = '0;
                    fwd_d      = !fwd_q;
                    w_rise_gen = !fwd_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (i_en) state_d = S_RUN;
                if (w_phase_end) begin
                    cnt_d = '0;
                    // The low phase always completes; the rise only happens if re-enabled.
                    if (fwd_q) begin
                        fwd_d = 1'b0;
                    end else if (i_en) begin
                        fwd_d      = 1'b1;
                        w_rise_gen = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                fwd_d   = 1'b0;
            end
        endcase

        rise_d    = w_rise_gen;
        running_d = (state_d != S_IDLE);
        cyc_d     = w_rise_gen ? (cyc_q + CNT_W'(1)) : cyc_q;

        // A pending value is freed before it is refilled, so a same-cycle capture is safe.
        w_xfer      = pend_full_q && ((state_q == S_IDLE) || w_rise_gen);
        div_act_d   = w_xfer ? pend_q : div_act_q;
        pend_full_d = pend_full_q && !w_xfer;
        pend_d      = pend_q;
        w_capture   = i_div_vld && !ack_q && (!pend_full_q || w_xfer);
        ack_d       = w_capture;
        if (w_capture) begin
            pend_d      = (i_div == '0) ? DIV_W'(1) : i_div;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_fpga_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_act_q   <= DIV_W'(1);
            pend_q      <= DIV_W'(1);
            pend_full_q <= 1'b0;
            ack_q       <= 1'b0;
            fwd_q       <= 1'b0;
            rise_q      <= 1'b0;
            running_q   <= 1'b0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_act_q   <= div_act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ack_q       <= ack_d;
            fwd_q       <= fwd_d;
            rise_q      <= rise_d;
            running_q   <= running_d;
            cyc_q       <= cyc_d;
        end
    end

    assign o_div_ack   = ack_q;
    assign o_fwd_clk   = fwd_q;
    assign o_running   = running_q;
    assign o_edge_rise = rise_q;
    assign o_cyc_cnt   = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_clk_gen
// Description : Directed self-checking bench for fwd_clk_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_clk_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             div_vld;
    logic             div_ack;
    logic             fwd_clk;
    logic             running;
    logic             edge_rise;
    logic [CNT_W-1:0] cyc_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fwd_clk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .i_fpga_clk (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_div      (div),
        .i_div_vld  (div_vld),
        .o_div_ack  (div_ack),
        .o_fwd_clk  (fwd_clk),
        .o_running  (running),
        .o_edge_rise(edge_rise),
        .o_cyc_cnt  (cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; div_vld = 1'b0; div = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Returns the number of cycles from request to visible ack (0 = never).
    task automatic send_div(input logic [DIV_W-1:0] v, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        div = v;
        div_vld = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            step();
            if (div_ack) begin
                got = 1'b1;
                lat = i;
            end
        end
        div_vld = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL send_div_timeout: ack not seen within 20 cycles, required ack");
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_f;
        do_reset();
        n_cmp++;
        if ({fwd_clk, running, edge_rise, div_ack, cyc_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got fwd=%b run=%b rise=%b ack=%b cnt=%0d, required all 0",
                     fwd_clk, running, edge_rise, div_ack, cyc_cnt);
        end
        step(); step();
        n_cmp++;
        if (fwd_clk !== 1'b0 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: got fwd=%b run=%b, required 0 0", fwd_clk, running);
        end
        // Divider left at its reset value of 1: period of two cycles.
        exp_f = 4'b0101;
        en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_cmp++;
            if (fwd_clk !== exp_f[c-1] || edge_rise !== exp_f[c-1] || running !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_div1 c%0d: got fwd=%b rise=%b run=%b, required fwd=%b rise=%b run=1",
                         c, fwd_clk, edge_rise, running, exp_f[c-1], exp_f[c-1]);
            end
        end
        n_cmp++;
        if (cyc_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL reset_div1_cnt: got %0d, required 2", cyc_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_div3();
        int lat;
        do_reset();
        send_div(8'd3, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL div3_ack_latency: got %0d, required 1", lat);
        end
        en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            n_cmp++;
            if (fwd_clk !== (((c - 1) % 6) < 3) || edge_rise !== (((c - 1) % 6) == 0)) begin
                n_bad++;
                $display("FAIL div3_wave c%0d: got fwd=%b rise=%b, required fwd=%b rise=%b",
                         c, fwd_clk, edge_rise, (((c - 1) % 6) < 3), (((c - 1) % 6) == 0));
            end
        end
        n_cmp++;
        if (cyc_cnt !== 8'd7) begin
            n_bad++;
            $display("FAIL div3_cyc_cnt: got %0d, required 7", cyc_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_div0();
        int lat;
        do_reset();
        send_div(8'd0, lat);
        en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            n_cmp++;
            if (fwd_clk !== c[0] || edge_rise !== c[0]) begin
                n_bad++;
                $display("FAIL div0_wave c%0d: got fwd=%b rise=%b, required %b %b",
                         c, fwd_clk, edge_rise, c[0], c[0]);
            end
        end
        n_cmp++;
        if (cyc_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL div0_cyc_cnt: got %0d, required 5", cyc_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_stop();
        int lat;
        logic exp_f, exp_r;
        do_reset();
        send_div(8'd4, lat);
        en = 1'b1;
        step();
        en = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            step();
            exp_f = (c <= 4);
            exp_r = (c <= 8);
            n_cmp++;
            if (fwd_clk !== exp_f || running !== exp_r || edge_rise !== 1'b0) begin
                n_bad++;
                $display("FAIL stop_wave c%0d: got fwd=%b run=%b rise=%b, required fwd=%b run=%b rise=0",
                         c, fwd_clk, running, edge_rise, exp_f, exp_r);
            end
        end
        en = 1'b1;
        step();
        n_cmp++;
        if (edge_rise !== 1'b1 || cyc_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL restart_cnt_kept: got rise=%b cnt=%0d, required rise=1 cnt=2", edge_rise, cyc_cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_reassert();
        int lat;
        logic exp_f, exp_r;
        do_reset();
        send_div(8'd3, lat);
        en = 1'b1;
        step();
        en = 1'b0;
        for (int c = 2; c <= 13; c++) begin
            step();
            exp_f = (c <= 3) || (c >= 7 && c <= 9) || (c == 13);
            exp_r = (c == 7) || (c == 13);
            n_cmp++;
            if (fwd_clk !== exp_f || edge_rise !== exp_r || running !== 1'b1) begin
                n_bad++;
                $display("FAIL reassert_wave c%0d: got fwd=%b rise=%b run=%b, required fwd=%b rise=%b run=1",
                         c, fwd_clk, edge_rise, running, exp_f, exp_r);
            end
            if (c == 5) en = 1'b1;
        end
        n_cmp++;
        if (dut.state_q !== 2'd1) begin
            n_bad++;
            $display("FAIL reassert_state: got %0d, required 1 (RUN)", dut.state_q);
        end
        en = 1'b0;
    endtask

    task automatic test_div_change();
        int lat;
        logic exp_f, exp_r, exp_a;
        do_reset();
        send_div(8'd2, lat);
        en = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            exp_f = (c <= 2) || (c >= 5 && c <= 9) || (c >= 15 && c[0]);
            exp_r = (c == 1) || (c == 5) || (c == 15) || (c == 17) || (c == 19);
            exp_a = (c == 3) || (c == 5);
            n_cmp++;
            if (fwd_clk !== exp_f || edge_rise !== exp_r || div_ack !== exp_a) begin
                n_bad++;
                $display("FAIL div_change c%0d: got fwd=%b rise=%b ack=%b, required fwd=%b rise=%b ack=%b",
                         c, fwd_clk, edge_rise, div_ack, exp_f, exp_r, exp_a);
            end
            if (c == 2) begin div = 8'd5; div_vld = 1'b1; end
            if (c == 3) div = 8'd1;
            if (c == 5) div_vld = 1'b0;
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        int lat;
        do_reset();
        send_div(8'd1, lat);
        en = 1'b1;
        for (int c = 1; c <= 509; c++) step();
        n_cmp++;
        if (cyc_cnt !== 8'd255 || edge_rise !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_pre: got cnt=%0d rise=%b, required 255 1", cyc_cnt, edge_rise);
        end
        step(); step();
        n_cmp++;
        if (cyc_cnt !== 8'd0 || edge_rise !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_zero: got cnt=%0d rise=%b, required 0 1", cyc_cnt, edge_rise);
        end
        en = 1'b0;
        do_reset();
        send_div(8'd4, lat);
        en = 1'b1;
        step(); step();
        n_cmp++;
        if (fwd_clk !== 1'b1 || cyc_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL mid_high_setup: got fwd=%b cnt=%0d, required 1 1", fwd_clk, cyc_cnt);
        end
        rst = 1'b1;
        en = 1'b0;
        step();
        n_cmp++;
        if ({fwd_clk, running, edge_rise, div_ack, cyc_cnt} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got fwd=%b run=%b rise=%b ack=%b cnt=%0d, required all 0",
                     fwd_clk, running, edge_rise, div_ack, cyc_cnt);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (fwd_clk !== 1'b0 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got fwd=%b run=%b, required 0 0", fwd_clk, running);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div = '0; div_vld = 1'b0;
        test_reset();
        test_div3();
        test_div0();
        test_stop();
        test_reassert();
        test_div_change();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_clk_gen.md
FWD_CLK_GEN -- requirements
Module: fwd_clk_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, giving the half-period divider width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the forwarded-period counter width.
REQ-003 i_fpga_clk  input  1  The block SHALL use this as its single clock; all logic is rising-edge.
REQ-004 i_rst  input  1  The block SHALL treat this as a synchronous, active-high reset.
REQ-005 i_en  input  1  Run request; level-sensitive.
REQ-006 i_div  input  DIV_W  Requested half-period in i_fpga_clk cycles; 0 is treated as 1.
REQ-007 i_div_vld  input  1  i_div valid; held high until o_div_ack.
REQ-008 o_div_ack  output  1  One-cycle pulse: i_div captured into the pending register.
REQ-009 o_fwd_clk  output  1  Registered forwarded clock, driven to the external differential output buffer.
REQ-010 o_running  output  1  High in RUN and STOP states.
REQ-011 o_edge_rise  output  1  One-cycle pulse in the same cycle o_fwd_clk goes 0->1.
REQ-012 o_cyc_cnt  output  CNT_W  Count of forwarded rising edges since reset.

Function
REQ-013 The block SHALL implement states IDLE, RUN and STOP, encoded as registered state.
REQ-014 In IDLE, o_fwd_clk SHALL be 0 and the half-period counter SHALL be held at 0.
REQ-015 When i_en=1 is sampled in IDLE at cycle k, the block SHALL enter RUN, with o_fwd_clk=1, o_edge_rise=1 and o_running=1 at cycle k+1.
REQ-016 The half-period counter SHALL increment every cycle in RUN and STOP.
REQ-017 When the counter equals div_eff-1, o_fwd_clk SHALL toggle and the counter SHALL clear.
  - Result: high and low phases of exactly div_eff cycles each; period = 2*div_eff.
REQ-018 div_eff SHALL be the active divider register, with i_div=0 stored as 1.
  - div_eff=1 yields o_fwd_clk at i_fpga_clk/2.
REQ-019 When i_en=0 is sampled in RUN, the block SHALL enter STOP.
  - The current period completes: the remaining high phase, if any, plus the full low phase.
  - At the end of the low phase the block returns to IDLE instead of producing a rising edge.
REQ-020 No truncated high or low phase SHALL be produced except by i_rst.
REQ-021 When i_en=1 is sampled in STOP, the block SHALL return to RUN with no break in the waveform.
REQ-022 Divider handshake: when i_div_vld=1 and the pending register is empty, the block SHALL capture i_div, mark pending full, and pulse o_div_ack the next cycle.
REQ-023 When i_div_vld=1 and pending is full, o_div_ack SHALL be withheld until pending empties.
REQ-024 In RUN or STOP, pending SHALL be transferred to the active divider only at a period boundary.
  - Period boundary: the cycle in which a rising edge is generated.
  - The new period uses the new value; pending then empties.
REQ-025 In IDLE, pending SHALL be transferred to the active divider on the cycle after capture.
REQ-026 If a boundary transfer and a new capture coincide, the block SHALL perform the transfer first, then capture the new value into the now-empty pending register in the same cycle.
REQ-027 o_cyc_cnt SHALL increment by 1 on every o_edge_rise and wrap from 2^CNT_W-1 to 0.
REQ-028 o_cyc_cnt SHALL NOT be cleared by IDLE/RUN transitions.

Reset
REQ-029 When i_rst=1 is sampled, the block SHALL, on the next cycle, force IDLE with the following values:
  - o_fwd_clk=0, o_running=0, o_edge_rise=0, o_div_ack=0, o_cyc_cnt=0.
  - Counter=0, pending empty, active divider=1.
REQ-030 Reset SHALL take priority over all other inputs, including mid-phase, where truncation is permitted.

Verification
REQ-031 The bench SHALL cover: reset; i_div=3 with ack; i_en=1 for 40 cycles -> o_fwd_clk 3 high/3 low, first rise one cycle after i_en; o_cyc_cnt=7 after 40 cycles.
REQ-032 The bench SHALL cover: i_div=0; i_en=1 -> o_fwd_clk toggles every cycle; an o_edge_rise on every other cycle.
REQ-033 The bench SHALL cover: i_div=4 running; i_en dropped 1 cycle into the high phase -> 3 more high cycles, 4 low cycles, then IDLE; o_running falls together with the final low phase end; no further rise.
REQ-034 The bench SHALL cover: running at i_div=2; i_div=5 presented mid-period -> ack within 1 cycle; current period stays 2+2; the next period is 5+5. A second i_div_vld issued before the boundary -> ack delayed until that boundary.
REQ-035 The bench SHALL cover: i_en dropped, then reasserted during the STOP low phase -> next rise exactly div_eff cycles after the falling edge, state RUN, no gap.
REQ-036 The bench SHALL cover: preload o_cyc_cnt near wrap (run 2^CNT_W-1 periods with div=1) -> next rise gives o_cyc_cnt=0. Then assert i_rst mid-high phase -> o_fwd_clk=0 and all outputs at reset values on the next cycle.
